// File: rtl/instr_field_buffer_if.sv
// instr_field_buffer_if: fetch-side and decode-side handshake bundle of the instruction field buffer
interface instr_field_buffer_if #(parameter int PC_W = 32);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [PC_W-1:0] in_pc;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [5:0]      out_opcode;
   logic [4:0]      out_rs;
   logic [4:0]      out_rt;
   logic [4:0]      out_rd;
   logic [10:0]     out_imm11;
   logic [PC_W-1:0] out_pc;
   logic            out_is_nop;
   modport master (
      output in_valid, in_instr, in_pc, flush, out_ready,
      input  in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd, out_imm11, out_pc, out_is_nop
   );
   modport slave (
      input  in_valid, in_instr, in_pc, flush, out_ready,
      output in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd, out_imm11, out_pc, out_is_nop
   );
endinterface

// File: rtl/instr_field_buffer.sv
// instr_field_buffer: two-entry (main + skid) decode buffer splitting the head word into fields; optional INSTR_FIELD_BUFFER_STALL_CNT_EN adds a saturating stall counter
module instr_field_buffer #(
   parameter int PC_W = 32
`ifdef INSTR_FIELD_BUFFER_STALL_CNT_EN
   , parameter int CNT_W = 16
`endif
) (
   input logic clk,
   input logic rst,
   instr_field_buffer_if.slave bus
`ifdef INSTR_FIELD_BUFFER_STALL_CNT_EN
   , output logic [CNT_W-1:0] stall_cnt
`endif
);
   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
   state_t state, state_nx;
   logic [31:0]     main_w, skid_w;
   logic [PC_W-1:0] main_pc, skid_pc;
   logic            accept, deliver;
   assign accept  = bus.in_valid & bus.in_ready;
   assign deliver = bus.out_valid & bus.out_ready;
   // state register; in_ready/out_valid decode straight from it, so they are registered
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= EMPTY;
      else     state <= state_nx;
   // next state; flush wins over any accept/deliver
   always_comb begin
      state_nx = state;
      if (bus.flush) state_nx = EMPTY;
      else case (state)
         EMPTY:   state_nx = accept ? ONE : EMPTY;
         ONE:     state_nx = (accept && !deliver) ? TWO : (deliver && !accept) ? EMPTY : ONE;
         TWO:     state_nx = deliver ? ONE : TWO;
         default: state_nx = EMPTY;
      endcase
   end
   // handshake outputs depend on state only, never on out_ready
   always_comb begin
      bus.in_ready  = state != TWO;
      bus.out_valid = state != EMPTY;
   end
   // main holds the head; skid catches the second word while the head is stalled
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         main_w  <= '0;
         main_pc <= '0;
         skid_w  <= '0;
         skid_pc <= '0;
      end else if (!bus.flush) begin
         if (accept && (state == EMPTY || deliver)) begin
            main_w  <= bus.in_instr;
            main_pc <= bus.in_pc;
         end else if (state == TWO && deliver) begin
            main_w  <= skid_w;
            main_pc <= skid_pc;
         end
         if (accept && state == ONE && !deliver) begin
            skid_w  <= bus.in_instr;
            skid_pc <= bus.in_pc;
         end
      end
   assign bus.out_opcode = main_w[31:26];
   assign bus.out_rs     = main_w[25:21];
   assign bus.out_rt     = main_w[20:16];
   assign bus.out_rd     = main_w[15:11];
   assign bus.out_imm11  = main_w[10:0];
   assign bus.out_pc     = main_pc;
   assign bus.out_is_nop = (state != EMPTY) && main_w == 32'h0;
`ifdef INSTR_FIELD_BUFFER_STALL_CNT_EN
   // count cycles the head waits on decode, holding at all-ones
   always_ff @(posedge clk or posedge rst)
      if (rst) stall_cnt <= '0;
      else if (bus.out_valid && !bus.out_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
`endif
endmodule
